// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and constants for sram_1r1w_arbiter
package sram_arb_pkg;

   localparam int RD_LAT      = 2;
   localparam int RESP_ID_W   = 3;   // enough for up to 8 requesters
   localparam int RESP_DATA_W = 64;  // widest supported WIDTH

   typedef enum logic {ST_INIT, ST_RUN} arb_state_e;

   typedef struct packed {
      logic                   valid;
      logic [RESP_ID_W-1:0]   id;
      logic                   byp;
      logic [RESP_DATA_W-1:0] byp_data;
   } resp_pipe_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts at ptr
module rr_arbiter #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   logic          w_found;
   logic [IW-1:0] w_idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      w_found = 1'b0;
      w_idx   = '0;
      for (int k = 0; k < N; k++) begin
         w_idx = IW'((int'(ptr) + k) % N);
         if (!w_found && req[w_idx]) begin
            w_found      = 1'b1;
            gnt[w_idx]   = 1'b1;
            gnt_idx      = w_idx;
         end
      end
   end

endmodule

// File: rtl/sram_1r1w_arbiter.sv
// rtl/sram_1r1w_arbiter.sv - NREQ-way round-robin sharing of a 1R1W SRAM
// with power-up zero-fill, response routing and same-address write forwarding.
module sram_1r1w_arbiter
   import sram_arb_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int DEPTH      = 64,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int NREQ       = 2,
   parameter int INIT_ZERO  = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   output logic                       init_done,
   input  logic [NREQ-1:0]            wr_valid,
   output logic [NREQ-1:0]            wr_ready,
   input  logic [NREQ*ADDR_WIDTH-1:0] wr_addr,
   input  logic [NREQ*WIDTH-1:0]      wr_data,
   input  logic [NREQ-1:0]            rd_valid,
   output logic [NREQ-1:0]            rd_ready,
   input  logic [NREQ*ADDR_WIDTH-1:0] rd_addr,
   output logic [NREQ-1:0]            rd_resp_valid,
   output logic [WIDTH-1:0]           rd_resp_data,
   output logic                       ram_wen,
   output logic [ADDR_WIDTH-1:0]      ram_waddr,
   output logic [WIDTH-1:0]           ram_wdata,
   output logic                       ram_ren,
   output logic [ADDR_WIDTH-1:0]      ram_raddr,
   input  logic [WIDTH-1:0]           ram_rdata
);

   localparam int IW = $clog2(NREQ);

   arb_state_e            r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_icnt, w_icnt_nxt;
   logic [IW-1:0]         r_wptr, r_rptr, w_widx, w_ridx;
   logic [NREQ-1:0]       w_wreq, w_rreq, w_wgnt, w_rgnt;
   logic                  w_init_act, w_run, w_byp;
   logic [ADDR_WIDTH-1:0] w_sel_waddr, w_sel_raddr, r_waddr_hold, r_raddr_hold;
   logic [WIDTH-1:0]      w_sel_wdata, r_wdata_hold;
   resp_pipe_t            r_pipe [RD_LAT];
   logic                  w_unused;

   // rst_n also gates the enables so nothing reaches the RAM or requesters while reset is held
   assign w_init_act = rst_n && (r_state == ST_INIT);
   assign w_run      = rst_n && (r_state == ST_RUN);
   assign init_done  = (r_state == ST_RUN);

   assign w_wreq = wr_valid & {NREQ{w_run}};
   assign w_rreq = rd_valid & {NREQ{w_run}};

   rr_arbiter #(.N(NREQ), .IW(IW)) u_wr_arb (
      .req     (w_wreq),
      .ptr     (r_wptr),
      .gnt     (w_wgnt),
      .gnt_idx (w_widx)
   );

   rr_arbiter #(.N(NREQ), .IW(IW)) u_rd_arb (
      .req     (w_rreq),
      .ptr     (r_rptr),
      .gnt     (w_rgnt),
      .gnt_idx (w_ridx)
   );

   assign w_sel_waddr = wr_addr[int'(w_widx)*ADDR_WIDTH +: ADDR_WIDTH];
   assign w_sel_wdata = wr_data[int'(w_widx)*WIDTH +: WIDTH];
   assign w_sel_raddr = rd_addr[int'(w_ridx)*ADDR_WIDTH +: ADDR_WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
         r_icnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_icnt  <= w_icnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_icnt_nxt  = r_icnt;
      ram_wen     = 1'b0;
      ram_waddr   = r_waddr_hold;
      ram_wdata   = r_wdata_hold;
      ram_ren     = 1'b0;
      ram_raddr   = r_raddr_hold;
      wr_ready    = '0;
      rd_ready    = '0;
      w_byp       = 1'b0;
      if (w_init_act) begin
         ram_wen    = 1'b1;
         ram_waddr  = r_icnt;
         ram_wdata  = '0;
         w_icnt_nxt = r_icnt + 1'b1;
         if (r_icnt == ADDR_WIDTH'(DEPTH - 1)) begin
            w_state_nxt = ST_RUN;
            w_icnt_nxt  = '0;
         end
      end else if (w_run) begin
         wr_ready = w_wgnt;
         rd_ready = w_rgnt;
         if (|w_wgnt) begin
            ram_wen   = 1'b1;
            ram_waddr = w_sel_waddr;
            ram_wdata = w_sel_wdata;
         end
         if (|w_rgnt) begin
            ram_ren   = 1'b1;
            ram_raddr = w_sel_raddr;
         end
         // macro read-during-write is undefined, so the read takes the write data instead
         w_byp = (|w_wgnt) && (|w_rgnt) && (w_sel_waddr == w_sel_raddr);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_waddr_hold <= '0;
         r_wdata_hold <= '0;
         r_raddr_hold <= '0;
         for (int s = 0; s < RD_LAT; s++) r_pipe[s] <= '0;
      end else begin
         if (|w_wgnt) r_wptr <= (w_widx == IW'(NREQ - 1)) ? '0 : w_widx + 1'b1;
         if (|w_rgnt) r_rptr <= (w_ridx == IW'(NREQ - 1)) ? '0 : w_ridx + 1'b1;
         if (ram_wen) begin
            r_waddr_hold <= ram_waddr;
            r_wdata_hold <= ram_wdata;
         end
         if (ram_ren) r_raddr_hold <= ram_raddr;
         r_pipe[0] <= '{valid:    ram_ren,
                        id:       RESP_ID_W'(w_ridx),
                        byp:      w_byp,
                        byp_data: RESP_DATA_W'(ram_wdata)};
         for (int s = 1; s < RD_LAT; s++) r_pipe[s] <= r_pipe[s-1];
      end
   end

   always_comb begin
      rd_resp_valid = '0;
      if (r_pipe[RD_LAT-1].valid) rd_resp_valid[r_pipe[RD_LAT-1].id[IW-1:0]] = 1'b1;
      rd_resp_data = r_pipe[RD_LAT-1].byp ? r_pipe[RD_LAT-1].byp_data[WIDTH-1:0] : ram_rdata;
   end

   assign w_unused = ^{r_pipe[RD_LAT-1].id, r_pipe[RD_LAT-1].byp_data};

endmodule

// File: tb/tb_sram_1r1w_arbiter.sv
// tb/tb_sram_1r1w_arbiter.sv - scoreboard bench for sram_1r1w_arbiter with a latency-2 RAM model
module tb_sram_1r1w_arbiter;

   localparam int WIDTH = 32;
   localparam int DEPTH = 64;
   localparam int AW    = 6;
   localparam int NREQ  = 2;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 init_done;
   logic [NREQ-1:0]      wr_valid, wr_ready, rd_valid, rd_ready, rd_resp_valid;
   logic [NREQ*AW-1:0]   wr_addr, rd_addr;
   logic [NREQ*WIDTH-1:0] wr_data;
   logic [WIDTH-1:0]     rd_resp_data, ram_wdata, ram_rdata;
   logic                 ram_wen, ram_ren;
   logic [AW-1:0]        ram_waddr, ram_raddr;

   always #5 clk = ~clk;

   sram_1r1w_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .NREQ(NREQ), .INIT_ZERO(1)) dut (
      .clk(clk), .rst_n(rst_n), .init_done(init_done),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
      .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
      .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
      .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
   );

   // RAM: garbage at power-up, garbage on read-during-write collision, data 2 cycles after ren
   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] ram_s1, ram_s2;
   bit               filled = 1'b0;
   always @(posedge clk) begin
      if (!rst_n && !filled) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= $urandom;
         filled <= 1'b1;
      end else begin
         ram_s2 <= ram_s1;
         if (ram_ren) ram_s1 <= (ram_wen && ram_waddr == ram_raddr) ? 32'h0BAD_F00D : mem[ram_raddr];
         if (ram_wen) mem[ram_waddr] <= ram_wdata;
      end
   end
   assign ram_rdata = ram_s2;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [AW-1:0] waddr_of(input int j);
      return wr_addr[j*AW +: AW];
   endfunction
   function automatic logic [AW-1:0] raddr_of(input int j);
      return rd_addr[j*AW +: AW];
   endfunction
   function automatic logic [WIDTH-1:0] wdata_of(input int j);
      return wr_data[j*WIDTH +: WIDTH];
   endfunction

   typedef struct {
      int               cyc;
      int               id;
      logic [WIDTH-1:0] data;
   } exp_t;

   exp_t             sb[$];
   logic [WIDTH-1:0] ref_mem [DEPTH];
   int               wptr_m, rptr_m;
   bit               model_en = 1'b0;
   bit               mon_en   = 1'b0;

   // reference: round-robin from a pointer, array memory, forwarding on same-cycle same-address
   always @(negedge clk) begin : model
      int              wi, ri, j;
      logic [NREQ-1:0] ew, er;
      exp_t            e;
      if (!rst_n) begin
         wptr_m = 0;
         rptr_m = 0;
         for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
         sb.delete();
      end else if (model_en) begin
         wi = -1; ri = -1; ew = '0; er = '0;
         for (int k = 0; k < NREQ; k++) begin
            j = (wptr_m + k) % NREQ;
            if (wi < 0 && wr_valid[j]) wi = j;
            j = (rptr_m + k) % NREQ;
            if (ri < 0 && rd_valid[j]) ri = j;
         end
         if (wi >= 0) begin ew[wi] = 1'b1; wptr_m = (wi + 1) % NREQ; end
         if (ri >= 0) begin er[ri] = 1'b1; rptr_m = (ri + 1) % NREQ; end
         chk("wr_ready", 64'(wr_ready), 64'(ew));
         chk("rd_ready", 64'(rd_ready), 64'(er));
         if (ri >= 0) begin
            e.cyc = cyc + 2;
            e.id  = ri;
            if (wi >= 0 && waddr_of(wi) == raddr_of(ri)) e.data = wdata_of(wi);
            else e.data = ref_mem[raddr_of(ri)];
            sb.push_back(e);
         end
         if (wi >= 0) ref_mem[waddr_of(wi)] = wdata_of(wi);
      end
   end

   always @(negedge clk) begin : monitor
      exp_t e;
      if (mon_en) begin
         while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            chk("resp_missing", 64'(rd_resp_valid), 64'(1) << e.id);
         end
         if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            chk("resp_valid", 64'(rd_resp_valid), 64'(1) << e.id);
            chk("resp_data", 64'(rd_resp_data), 64'(e.data));
         end else begin
            chk("resp_idle", 64'(rd_resp_valid), 64'(0));
         end
      end
   end

   // releases reset with requests pending and checks the zero-fill walk
   task automatic do_init();
      wr_valid = '1;
      rd_valid = '1;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         chk("init_done_low", 64'(init_done), 64'(0));
         chk("init_wen", 64'(ram_wen), 64'(1));
         chk("init_waddr", 64'(ram_waddr), 64'(i));
         chk("init_wdata", 64'(ram_wdata), 64'(0));
         chk("init_held_off", 64'({wr_ready, rd_ready, ram_ren}), 64'(0));
         tick();
      end
      wr_valid = '0;
      rd_valid = '0;
      @(negedge clk);
      chk("init_done_high", 64'(init_done), 64'(1));
      model_en = 1'b1;
   endtask

   task automatic random_traffic(input int n);
      for (int c = 0; c < n; c++) begin
         wr_valid = NREQ'($urandom);
         rd_valid = NREQ'($urandom);
         for (int j = 0; j < NREQ; j++) begin
            wr_addr[j*AW +: AW]       = AW'($urandom_range(0, 7));
            rd_addr[j*AW +: AW]       = AW'($urandom_range(0, 7));
            wr_data[j*WIDTH +: WIDTH] = $urandom;
         end
         tick();
      end
      wr_valid = '0;
      rd_valid = '0;
      repeat (4) tick();
   endtask

   logic [1:0] fair [4];

   initial begin
      fair = '{2'b01, 2'b10, 2'b01, 2'b10};
      rst_n = 1'b0;
      wr_valid = '0; rd_valid = '0; wr_addr = '0; rd_addr = '0; wr_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_init_done", 64'(init_done), 64'(0));
      chk("rst_outputs", 64'({wr_ready, rd_ready, rd_resp_valid, ram_wen, ram_ren}), 64'(0));
      mon_en = 1'b1;
      do_init();
      tick();

      wr_valid = 2'b11; wr_addr = {6'd21, 6'd20}; wr_data = {$urandom, $urandom};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("wr_fair", 64'(wr_ready), 64'(fair[i]));
         tick();
      end
      wr_valid = '0;
      rd_valid = 2'b11; rd_addr = {6'd21, 6'd20};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rd_fair", 64'(rd_ready), 64'(fair[i]));
         tick();
      end
      rd_valid = '0;
      repeat (3) tick();

      rd_valid = 2'b01; rd_addr = {6'd0, 6'd5};
      tick();
      rd_valid = '0;
      tick();
      @(negedge clk);
      chk("read_after_init", 64'(rd_resp_data), 64'(0));
      tick();

      wr_valid = 2'b01; wr_addr = {6'd0, 6'd7}; wr_data = {32'h0, 32'hDEADBEEF};
      rd_valid = 2'b10; rd_addr = {6'd7, 6'd0};
      tick();
      wr_valid = '0; rd_valid = 2'b01; rd_addr = {6'd0, 6'd7};
      tick();
      rd_valid = '0;
      @(negedge clk);
      chk("byp_same_cycle", 64'(rd_resp_data), 64'(32'hDEADBEEF));
      tick();
      @(negedge clk);
      chk("byp_next_cycle", 64'(rd_resp_data), 64'(32'hDEADBEEF));
      tick();

      wr_valid = 2'b01; wr_addr = {6'd0, 6'd9}; wr_data = {32'h0, 32'h11};
      tick();
      wr_valid = '0;
      tick();
      rd_valid = 2'b01; rd_addr = {6'd0, 6'd9};
      tick();
      rd_valid = '0;
      wr_valid = 2'b01; wr_data = {32'h0, 32'h22};
      tick();
      wr_valid = '0;
      @(negedge clk);
      chk("old_data", 64'(rd_resp_data), 64'(32'h11));
      tick();

      random_traffic(400);

      rd_valid = 2'b01; rd_addr = {6'd0, 6'd3};
      tick();
      rd_valid = '0;
      model_en = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_init_done", 64'(init_done), 64'(0));
      tick();
      do_init();
      tick();

      random_traffic(150);
      chk("sb_drained", 64'(sb.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
